// File: rtl/pwm_timebase_ctrl_if.sv
// Configuration and status bundle for the PWM timebase sequencer.
// The master side supplies the synchronised configuration word and the run
// request. The slave side (the sequencer) returns the waveform and status.
interface pwm_timebase_ctrl_if;

    logic        enable;       // 1 = run PWM, 0 = idle
    logic [15:0] cfg_data;     // requested duty, in counts
    logic [3:0]  cfg_prd;      // requested period code
    logic [2:0]  cfg_res;      // requested resolution code
    logic        cfg_pol;      // requested polarity: 0 = idle low, 1 = idle high

    logic        pwm_out;      // registered PWM waveform
    logic        period_end;   // one-cycle pulse in the first cycle of a new period
    logic        cfg_pending;  // changed configuration waiting for a period boundary
    logic        busy;         // high while running

    modport master (
        output enable,
        output cfg_data,
        output cfg_prd,
        output cfg_res,
        output cfg_pol,
        input  pwm_out,
        input  period_end,
        input  cfg_pending,
        input  busy
    );

    modport slave (
        input  enable,
        input  cfg_data,
        input  cfg_prd,
        input  cfg_res,
        input  cfg_pol,
        output pwm_out,
        output period_end,
        output cfg_pending,
        output busy
    );

endinterface

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase sequencer.
// A prescaler divides core_clk down to counter steps, and the period counter
// runs 0 .. 2^N-1. The configuration is held in shadow registers that only
// reload at a period boundary, or whenever the block is idle, so a running
// waveform never shows a runt or glitched pulse. The period length is
// m * STEP_DIV * 4096 cycles whatever the resolution: a finer resolution
// gives proportionally fewer core_clk cycles per step.
module pwm_timebase_ctrl #(
    parameter int unsigned STEP_DIV = 16  // power of two, >= 16
) (
    input  logic               core_clk,
    input  logic               rsn,
    pwm_timebase_ctrl_if.slave bus
);

    localparam int unsigned SD_LOG2 = $clog2(STEP_DIV);
    // The largest divider is 8 * STEP_DIV, so DIV-1 always fits in PS_W bits.
    localparam int unsigned PS_W    = SD_LOG2 + 3;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PS_W-1:0]   prescaler_q, prescaler_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [15:0]       shadow_data_q, shadow_data_d;
    logic [3:0]        shadow_prd_q, shadow_prd_d;
    logic [2:0]        shadow_res_q, shadow_res_d;
    logic              shadow_pol_q, shadow_pol_d;
    logic              pwm_out_q, pwm_out_d;
    logic              period_end_q, period_end_d;
    logic              cfg_pending_q, cfg_pending_d;
    logic              busy_q, busy_d;

    // Decoded timing values, derived from the shadow registers only.
    logic [2:0]        prd_clamp;
    logic [3:0]        mult;
    logic [2:0]        res_clamp;
    logic [PS_W:0]     div_full;
    logic [PS_W-1:0]   div_m1;
    logic [16:0]       full_scale;
    logic [16:0]       duty_eff;
    logic              active;
    logic [7:0]        at_top_res;
    logic              at_top;
    logic              step;
    logic              wrap;
    logic              cfg_change;
    logic              load_shadow;

    // Terminal-count detect for each resolution code. A code above 4 is
    // clamped to 16 bits. The counter never exceeds 2^N-1, so an all-ones
    // low slice means the counter is at the last count of the period.
    for (genvar gi = 0; gi < 8; gi++) begin : g_top
        localparam int TOP_BIT = (gi > 4) ? 15 : 11 + gi;
        assign at_top_res[gi] = &counter_q[TOP_BIT:0];
    end

    // Decode the period multiplier, the resolution, the prescaler divider and the duty limit.
    always_comb begin
        prd_clamp  = (shadow_prd_q > 4'd7) ? 3'd7 : shadow_prd_q[2:0];
        mult       = (prd_clamp == 3'd0) ? 4'd2 : {1'b0, prd_clamp} + 4'd1;
        res_clamp  = (shadow_res_q > 3'd4) ? 3'd4 : shadow_res_q;
        // DIV = m * (STEP_DIV >> res) = m << (log2(STEP_DIV) - res)
        div_full   = {{(PS_W - 3){1'b0}}, mult} << (SD_LOG2 - 32'(res_clamp));
        div_m1     = PS_W'(div_full - (PS_W + 1)'(1));
        full_scale = 17'd1 << (32'd12 + 32'(res_clamp));
        // A duty at or beyond full scale means the output is active all the time.
        duty_eff   = ({1'b0, shadow_data_q} >= full_scale) ? full_scale
                                                           : {1'b0, shadow_data_q};
        active     = ({1'b0, counter_q} < duty_eff);
        at_top     = at_top_res[res_clamp];
        step       = (prescaler_q == div_m1);
        wrap       = step && at_top;
        cfg_change = ({bus.cfg_data, bus.cfg_prd, bus.cfg_res, bus.cfg_pol} !=
                      {shadow_data_q, shadow_prd_q, shadow_res_q, shadow_pol_q});
    end

    // Next-state logic for the sequencer FSM, the counters, the shadow registers and the outputs.
    always_comb begin
        state_d        = state_q;
        prescaler_d    = prescaler_q;
        counter_d      = counter_q;
        shadow_data_d  = shadow_data_q;
        shadow_prd_d   = shadow_prd_q;
        shadow_res_d   = shadow_res_q;
        shadow_pol_d   = shadow_pol_q;
        pwm_out_d      = pwm_out_q;
        period_end_d   = 1'b0;
        cfg_pending_d  = 1'b0;
        load_shadow    = 1'b0;

        case (state_q)
            IDLE: begin
                prescaler_d = '0;
                counter_d   = '0;
                pwm_out_d   = shadow_pol_q;
                // While idle there is no waveform to protect, so a new
                // configuration is taken at once and nothing is left pending.
                load_shadow = cfg_change;
                if (bus.enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    // Truncate the period. Any waiting configuration lands now.
                    // The idle level follows the polarity that is in force
                    // after this edge, so the output does not toggle once more
                    // on the next cycle.
                    state_d     = IDLE;
                    prescaler_d = '0;
                    counter_d   = '0;
                    load_shadow = cfg_change;
                    pwm_out_d   = cfg_change ? bus.cfg_pol : shadow_pol_q;
                end else begin
                    prescaler_d = step ? '0 : prescaler_q + PS_W'(1);
                    if (step) begin
                        counter_d = wrap ? '0 : counter_q + 16'd1;
                    end
                    period_end_d  = wrap;
                    pwm_out_d     = shadow_pol_q ^ active;
                    // The latest live value is the one taken at the boundary.
                    // A change in the wrap cycle itself is taken at that wrap.
                    load_shadow   = wrap && cfg_change;
                    cfg_pending_d = cfg_change && !wrap;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh configuration always starts counting from zero, so a smaller
        // N or DIV never sees a count that is out of range.
        if (load_shadow) begin
            shadow_data_d = bus.cfg_data;
            shadow_prd_d  = bus.cfg_prd;
            shadow_res_d  = bus.cfg_res;
            shadow_pol_d  = bus.cfg_pol;
            prescaler_d   = '0;
            counter_d     = '0;
        end

        busy_d = (state_d == RUN);
    end

    // State register. Reset is synchronous and overrides everything on the same edge.
    always_ff @(posedge core_clk) begin
        if (rsn) begin
            state_q       <= IDLE;
            prescaler_q   <= '0;
            counter_q     <= '0;
            shadow_data_q <= '0;
            shadow_prd_q  <= '0;
            shadow_res_q  <= '0;
            shadow_pol_q  <= 1'b0;
            pwm_out_q     <= 1'b0;
            period_end_q  <= 1'b0;
            cfg_pending_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prescaler_q   <= prescaler_d;
            counter_q     <= counter_d;
            shadow_data_q <= shadow_data_d;
            shadow_prd_q  <= shadow_prd_d;
            shadow_res_q  <= shadow_res_d;
            shadow_pol_q  <= shadow_pol_d;
            pwm_out_q     <= pwm_out_d;
            period_end_q  <= period_end_d;
            cfg_pending_q <= cfg_pending_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.pwm_out     = pwm_out_q;
    assign bus.period_end  = period_end_q;
    assign bus.cfg_pending = cfg_pending_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// Directed bench for pwm_timebase_ctrl with STEP_DIV = 16.
// Each stimulus step first queues the output values it should produce, each
// tagged with the core_clk edge count at which it must hold. Just after every
// falling edge the entries that are due are popped and compared.
// Edge numbers inside a run are counted from the edge that samples enable=1.
module tb_pwm_timebase_ctrl;

    localparam int SIG_PWM  = 0;
    localparam int SIG_PE   = 1;
    localparam int SIG_PEND = 2;
    localparam int SIG_BUSY = 3;

    typedef struct {
        string  tag;
        longint due;
        int     sel;
        logic   exp;
    } exp_t;

    logic   core_clk = 1'b0;
    logic   rsn;
    exp_t   sb[$];
    int     n_asserts = 0;
    int     n_fail    = 0;
    longint cyc       = 0;
    longint base;
    longint c;

    pwm_timebase_ctrl_if bus ();

    pwm_timebase_ctrl #(.STEP_DIV(16)) dut (
        .core_clk (core_clk),
        .rsn      (rsn),
        .bus      (bus)
    );

    always #5 core_clk = ~core_clk;

    function automatic logic observe(int sel);
        case (sel)
            SIG_PWM:  return bus.pwm_out;
            SIG_PE:   return bus.period_end;
            SIG_PEND: return bus.cfg_pending;
            default:  return bus.busy;
        endcase
    endfunction

    task automatic expect_at(string tag, longint due, int sel, logic exp);
        exp_t e;
        e.tag = tag;
        e.due = due;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_due();
        logic obs;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                obs = observe(sb[i].sel);
                n_asserts++;
                assert (obs === sb[i].exp)
                    $display("check %s at edge %0d: observed %b", sb[i].tag, cyc, obs);
                else begin
                    n_fail++;
                    $error("FAIL %s at edge %0d: observed %b expected %b",
                           sb[i].tag, cyc, obs, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        cyc++;
        @(negedge core_clk);
        check_due();
    endtask

    task automatic wait_to(longint t);
        while (cyc < t) tick();
    endtask

    task automatic set_cfg(logic [15:0] d, logic [3:0] p, logic [2:0] r, logic pol);
        bus.cfg_data = d;
        bus.cfg_prd  = p;
        bus.cfg_res  = r;
        bus.cfg_pol  = pol;
    endtask

    initial begin
        // Reset: every output must be 0 while rsn is held.
        rsn        = 1'b1;
        bus.enable = 1'b0;
        set_cfg(16'h0000, 4'h0, 3'h0, 1'b0);
        c = cyc;
        expect_at("rst_pwm",  c + 2, SIG_PWM,  1'b0);
        expect_at("rst_pe",   c + 2, SIG_PE,   1'b0);
        expect_at("rst_pend", c + 2, SIG_PEND, 1'b0);
        expect_at("rst_busy", c + 2, SIG_BUSY, 1'b0);
        repeat (3) tick();
        rsn = 1'b0;

        // A change while idle loads the shadow in one cycle and never shows as pending.
        c = cyc;
        expect_at("idle_pwm_old", c + 1, SIG_PWM,  1'b0);
        expect_at("idle_pend_a",  c + 1, SIG_PEND, 1'b0);
        expect_at("idle_pwm_pol", c + 2, SIG_PWM,  1'b1);
        expect_at("idle_pend_b",  c + 2, SIG_PEND, 1'b0);
        expect_at("idle_busy",    c + 2, SIG_BUSY, 1'b0);
        set_cfg(16'h0010, 4'hF, 3'h7, 1'b1);   // prd and res clamp to m=8, N=16, so DIV=8
        wait_to(c + 4);

        // Run A: inverted polarity and the clamped prd/res codes, then reset in mid-run.
        base = cyc + 1;
        expect_at("a_busy",     base,       SIG_BUSY, 1'b1);
        expect_at("a_pwm_idle", base,       SIG_PWM,  1'b1);
        expect_at("a_pwm_act",  base + 1,   SIG_PWM,  1'b0);
        expect_at("a_pwm_128",  base + 128, SIG_PWM,  1'b0);
        expect_at("a_pwm_129",  base + 129, SIG_PWM,  1'b1);
        expect_at("a_pe_129",   base + 129, SIG_PE,   1'b0);
        expect_at("a_pend_200", base + 200, SIG_PEND, 1'b0);
        expect_at("a_pend_201", base + 201, SIG_PEND, 1'b1);
        expect_at("a_pend_219", base + 219, SIG_PEND, 1'b1);
        expect_at("a_pwm_219",  base + 219, SIG_PWM,  1'b1);
        expect_at("a_rst_pwm",  base + 220, SIG_PWM,  1'b0);
        expect_at("a_rst_busy", base + 220, SIG_BUSY, 1'b0);
        expect_at("a_rst_pend", base + 220, SIG_PEND, 1'b0);
        expect_at("a_rst_pe",   base + 220, SIG_PE,   1'b0);
        bus.enable = 1'b1;
        wait_to(base + 200);
        bus.cfg_data = 16'h0020;
        wait_to(base + 219);
        rsn = 1'b1;
        wait_to(base + 221);
        rsn        = 1'b0;
        bus.enable = 1'b0;
        set_cfg(16'h0010, 4'hF, 3'h7, 1'b1);
        wait_to(cyc + 3);

        // Run B: disabling while the output is active returns it to the idle level at once.
        base = cyc + 1;
        expect_at("b_pwm_idle", base,      SIG_PWM,  1'b1);
        expect_at("b_pwm_act",  base + 1,  SIG_PWM,  1'b0);
        expect_at("b_pwm_59",   base + 59, SIG_PWM,  1'b0);
        expect_at("b_busy_59",  base + 59, SIG_BUSY, 1'b1);
        expect_at("b_pwm_dis",  base + 60, SIG_PWM,  1'b1);
        expect_at("b_busy_dis", base + 60, SIG_BUSY, 1'b0);
        bus.enable = 1'b1;
        wait_to(base + 59);
        bus.enable = 1'b0;
        wait_to(base + 62);

        // Run D: N=16 with prd=0, giving m=2 and DIV=2. 0x1000 is below full scale, so it ends at count 4096.
        set_cfg(16'h1000, 4'h0, 3'h4, 1'b0);
        wait_to(cyc + 3);
        base = cyc + 1;
        expect_at("d_pwm_1",    base + 1,    SIG_PWM, 1'b1);
        expect_at("d_pwm_8192", base + 8192, SIG_PWM, 1'b1);
        expect_at("d_pwm_8193", base + 8193, SIG_PWM, 1'b0);
        expect_at("d_pe_8193",  base + 8193, SIG_PE,  1'b0);
        bus.enable = 1'b1;
        wait_to(base + 8200);
        bus.enable = 1'b0;
        wait_to(cyc + 3);

        // Run C: zero duty never produces a pulse.
        set_cfg(16'h0000, 4'h1, 3'h0, 1'b0);
        wait_to(cyc + 3);
        base = cyc + 1;
        expect_at("z_busy",    base + 1,   SIG_BUSY, 1'b1);
        expect_at("z_pwm_1",   base + 1,   SIG_PWM,  1'b0);
        expect_at("z_pwm_33",  base + 33,  SIG_PWM,  1'b0);
        expect_at("z_pwm_500", base + 500, SIG_PWM,  1'b0);
        bus.enable = 1'b1;
        wait_to(base + 510);
        bus.enable = 1'b0;
        wait_to(cyc + 3);

        // Long run: 50% duty over a 131072-cycle period. Two changes arrive in
        // mid-period, and only the later one (0x1000, 100%) lands at the wrap.
        set_cfg(16'h0800, 4'h1, 3'h0, 1'b0);
        wait_to(cyc + 3);
        base = cyc + 1;
        expect_at("p_pwm_1",      base + 1,              SIG_PWM,  1'b1);
        expect_at("p_pend_1000",  base + 1000,           SIG_PEND, 1'b0);
        expect_at("p_pend_1001",  base + 1001,           SIG_PEND, 1'b1);
        expect_at("p_pwm_65536",  base + 65536,          SIG_PWM,  1'b1);
        expect_at("p_pwm_65537",  base + 65537,          SIG_PWM,  1'b0);
        expect_at("p_pe_pre",     base + 131071,         SIG_PE,   1'b0);
        expect_at("p_pend_pre",   base + 131071,         SIG_PEND, 1'b1);
        expect_at("p_pe_wrap",    base + 131072,         SIG_PE,   1'b1);
        expect_at("p_pend_wrap",  base + 131072,         SIG_PEND, 1'b0);
        expect_at("p_pwm_wrap",   base + 131072,         SIG_PWM,  1'b0);
        expect_at("p_pe_post",    base + 131073,         SIG_PE,   1'b0);
        expect_at("p_pend_post",  base + 131073,         SIG_PEND, 1'b0);
        expect_at("p_pwm_new",    base + 131073,         SIG_PWM,  1'b1);
        expect_at("p_pwm_not300", base + 131072 + 24577, SIG_PWM,  1'b1);
        expect_at("p_pwm_not800", base + 131072 + 65537, SIG_PWM,  1'b1);
        expect_at("p_pwm_end2",   base + 262143,         SIG_PWM,  1'b1);
        expect_at("p_pe_wrap2",   base + 262144,         SIG_PE,   1'b1);
        expect_at("p_pwm_wrap2",  base + 262144,         SIG_PWM,  1'b1);
        expect_at("p_pwm_post2",  base + 262145,         SIG_PWM,  1'b1);
        bus.enable = 1'b1;
        wait_to(base + 1000);
        bus.cfg_data = 16'h0300;
        wait_to(base + 2000);
        bus.cfg_data = 16'h1000;
        wait_to(base + 262146);
        bus.enable = 1'b0;
        wait_to(cyc + 2);

        while (sb.size() > 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL %s: never sampled, expected %b at edge %0d",
                   sb[0].tag, sb[0].exp, sb[0].due);
            void'(sb.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
